// File: rtl/intdiv_seq_pkg.sv
// Shared types for the sequential divide/modulo unit: ALU function codes and divider FSM states.
package intdiv_seq_pkg;

  typedef enum logic [3:0] {
    INT_ADD  = 4'h0,
    INT_SUB  = 4'h1,
    INT_MUL  = 4'h2,
    INT_AND  = 4'h3,
    INT_OR   = 4'h4,
    INT_XOR  = 4'h5,
    INT_DIV  = 4'h6,
    INT_MOD  = 4'h7,
    INT_DIVU = 4'h8,
    INT_MODU = 4'h9
  } intfunc_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  function automatic logic is_div(intfunc_t f);
    return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
  endfunction

  function automatic logic is_signed_func(intfunc_t f);
    return (f == INT_DIV) || (f == INT_MOD);
  endfunction

  function automatic logic is_mod(intfunc_t f);
    return (f == INT_MOD) || (f == INT_MODU);
  endfunction

endpackage

// File: rtl/intdiv_seq_if.sv
// Request/response handshake between the execute stage (master) and the divider (slave).
interface intdiv_seq_if
  import intdiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  intfunc_t         func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div0;

  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, result, div0
  );

  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, result, div0
  );

endinterface

// File: rtl/intdiv_seq_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and record the quotient bit.
module intdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic           fits;
  // The partial remainder is always below the divisor, so its top bit is never set on entry.
  logic           unused_carry;

  assign unused_carry = rem_i[WIDTH];

  // NOTE: combinational block uses blocking '=' so each line sees the value computed just above.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
    fits    = (shifted >= {1'b0, d_i});
    rem_o   = fits ? (shifted - {1'b0, d_i}) : shifted;
    q_o     = {q_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/intdiv_seq.sv
// Multi-cycle signed/unsigned integer divide and modulo, one quotient bit per clock,
// with valid/ready on both request and result sides.
module intdiv_seq
  import intdiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  intdiv_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  intfunc_t         func_q, func_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             sgn_in;

  intdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .q_i   (quo_q),
    .d_i   (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_quo)
  );

  // Magnitude of the most negative value reads back as itself, which is the correct unsigned magnitude.
  assign sgn_in  = is_signed_func(bus.func);
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    div0_d    = div0_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.in_valid) begin
          func_d = bus.func;
          rem_d  = '0;
          cnt_d  = '0;
          if (!is_div(bus.func)) begin
            result_d = '0;
            div0_d   = 1'b0;
            state_d  = DIV_DONE;
          end else if (bus.b == '0) begin
            result_d = is_mod(bus.func) ? bus.a : '1;
            div0_d   = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            neg_quo_d = sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_d = sgn_in & bus.a[WIDTH-1];
            quo_d     = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            dvs_d     = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            div0_d    = 1'b0;
            state_d   = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        result_d = is_mod(func_q) ? rem_fix : quo_fix;
        state_d  = DIV_DONE;
      end
      DIV_DONE: begin
        if (bus.out_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      func_q    <= INT_ADD;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.in_ready  = (state_q == DIV_IDLE);
  assign bus.out_valid = (state_q == DIV_DONE);
  assign bus.result    = result_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed and randomized checks of intdiv_seq results, div0 flag, latency and handshake.
module tb_intdiv_seq;
  import intdiv_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  intdiv_seq_if #(.WIDTH(W)) bus ();

  intdiv_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; lat counts edges from accept to out_valid.
  task automatic wait_result(input string tag, output logic [W-1:0] res, output logic d0,
                             output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
    res = bus.result;
    d0  = bus.div0;
  endtask

  task automatic issue(input string tag, input intfunc_t f, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func     = f;
    bus.a        = a;
    bus.b        = b;
    if (!bus.in_ready) check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic vec(input string tag, input intfunc_t f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_d0,
                     input int exp_lat);
    logic [W-1:0] res;
    logic         d0;
    int           lat;
    issue(tag, f, a, b);
    wait_result(tag, res, d0, lat);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_div0"}, 32'(d0), 32'(exp_d0));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    handshake();
  endtask

  task automatic model(input intfunc_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic d0);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    d0 = (b == '0);
    if (b == '0) begin
      res = (f == INT_MOD || f == INT_MODU) ? a : '1;
    end else begin
      case (f)
        INT_DIVU: res = a / b;
        INT_MODU: res = a % b;
        INT_DIV:  res = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : W'(sa / sb);
        INT_MOD:  res = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? '0 : W'(sa % sb);
        default:  res = '0;
      endcase
    end
  endtask

  function automatic logic [W-1:0] pick(input int mode);
    logic [W-1:0] edges [8];
    edges = '{32'd0, 32'd1, 32'd2, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
              32'hFFFF_FFFE};
    case (mode)
      0:       return W'($urandom);
      1:       return W'($urandom_range(1, 300));
      2:       return W'(-$signed(W'($urandom_range(1, 300))));
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res, exp_res;
    logic         d0, exp_d0;
    int           lat;
    intfunc_t     f;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.func      = INT_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_div0", 32'(bus.div0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vec("divu_100_7",  INT_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 34);
    vec("modu_100_7",  INT_MODU, 32'd100,       32'd7,         32'd2,         1'b0, 34);
    vec("div_m100_7",  INT_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 34);
    vec("mod_m100_7",  INT_MOD,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, 34);
    vec("mod_100_m7",  INT_MOD,  32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0, 34);
    vec("div_min_m1",  INT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
    vec("mod_min_m1",  INT_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 34);
    vec("divu_max_1",  INT_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 34);
    vec("divu_5_0",    INT_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1);
    vec("modu_5_0",    INT_MODU, 32'd5,         32'd0,         32'd5,         1'b1, 1);
    vec("mod_m5_0",    INT_MOD,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, 1);
    vec("divu_3_10",   INT_DIVU, 32'd3,         32'd10,        32'd0,         1'b0, 34);
    vec("modu_3_10",   INT_MODU, 32'd3,         32'd10,        32'd3,         1'b0, 34);
    vec("div_7_m2",    INT_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
    vec("mod_7_m2",    INT_MOD,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 34);
    vec("add_nondiv",  INT_ADD,  32'd1,         32'd2,         32'd0,         1'b0, 1);

    // Result held in DONE while the consumer stalls; a pending request must be ignored.
    issue("hold", INT_DIVU, 32'd1000, 32'd10);
    wait_result("hold", res, d0, lat);
    check("hold_first", res, 32'd100);
    bus.in_valid = 1'b1;
    bus.func     = INT_DIVU;
    bus.a        = 32'd50;
    bus.b        = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", bus.result, 32'd100);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("b2b_idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_result("b2b", res, d0, lat);
    check("b2b_res", res, 32'd10);
    check("b2b_lat", 32'(lat), 32'd34);
    handshake();

    // Consumer already ready when the result appears: one-cycle DONE.
    bus.out_ready = 1'b1;
    issue("early_rdy", INT_DIVU, 32'd9, 32'd3);
    wait_result("early_rdy", res, d0, lat);
    check("early_rdy_res", res, 32'd3);
    @(negedge clk);
    check("early_rdy_out_valid", 32'(bus.out_valid), 32'd0);
    check("early_rdy_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // Reset in the middle of the iteration (count=10) aborts the operation.
    issue("abort", INT_DIVU, 32'h0000_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    check("abort_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    check("abort_no_spurious", 32'(lat), 32'd0);
    vec("after_abort", INT_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34);

    // Randomized operands against the language's own '/' and '%'.
    for (int n = 0; n < 250; n++) begin
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 3))
        0:       f = INT_DIV;
        1:       f = INT_MOD;
        2:       f = INT_DIVU;
        default: f = INT_MODU;
      endcase
      ra = pick($urandom_range(0, 3));
      rb = pick($urandom_range(0, 3));
      model(f, ra, rb, exp_res, exp_d0);
      vec($sformatf("rnd%0d_%s_%08h_%08h", n, f.name(), ra, rb), f, ra, rb, exp_res, exp_d0,
          (rb == '0) ? 1 : 34);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
